// File: rtl/mul_share_pkg.sv
// Shared types and constants for the time-multiplexed 32x32 multiplier sequencer.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int HALF_W = 16;
    localparam int PROD_W = 64;

    // Left shift applied to each partial product, indexed by issue step.
    localparam int PP_SHIFT [4] = '{0, 16, 16, 32};

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul16_cell.sv
// 16x16 unsigned multiplier with a single registered output stage.
module mul16_cell
    import mul_share_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            p <= '0;
        else if (en)
            p <= (2*HALF_W)'(a) * (2*HALF_W)'(b);
    end

endmodule

// File: rtl/mul_share_seq.sv
// Round-robin sequencer sharing one 16x16 multiplier cell among NUM_REQ requesters;
// each 32x32 product is built from four partial products shift-accumulated into a 64-bit register.
module mul_share_seq
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_src1,
    input  logic [NUM_REQ-1:0][31:0] req_src2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_lo,
    output logic [31:0]             rsp_hi,
    output logic                    busy
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr, id_q, grant_id, rr_nxt;
    logic                grant_vld, accept;
    logic [31:0]         a_q, b_q;
    logic [1:0]          step, acc_sel;
    logic                acc_en, mul_en;
    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [2*HALF_W-1:0] pp;
    logic [PROD_W-1:0]   acc, pp_shifted;

    // Scan from rr_ptr upward with wrap; descending loop so the nearest valid wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign accept = (state == IDLE) && grant_vld;
    assign rr_nxt = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   if (step == 2'd3) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // step[1] selects the A half, step[0] the B half.
    assign mul_en = (state == ISSUE);
    assign mul_a  = step[1] ? a_q[31:16] : a_q[15:0];
    assign mul_b  = step[0] ? b_q[31:16] : b_q[15:0];

    mul16_cell u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (mul_en),
        .a       (mul_a),
        .b       (mul_b),
        .p       (pp)
    );

    // The cell output always belongs to the previous issue step.
    assign acc_en     = ((state == ISSUE) && (step != 2'd0)) || (state == DRAIN);
    assign acc_sel    = (state == DRAIN) ? 2'd3 : step - 2'd1;
    assign pp_shifted = {{(PROD_W-2*HALF_W){1'b0}}, pp} << PP_SHIFT[acc_sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            step   <= '0;
            acc    <= '0;
        end else if (accept) begin
            rr_ptr <= rr_nxt;
            id_q   <= grant_id;
            a_q    <= req_src1[grant_id];
            b_q    <= req_src2[grant_id];
            step   <= '0;
            acc    <= '0;
        end else begin
            if (state == ISSUE)
                step <= step + 2'd1;
            if (acc_en)
                acc <= acc + pp_shifted;
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = id_q;
    assign rsp_lo    = acc[31:0];
    assign rsp_hi    = acc[63:32];
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_share_seq.sv
// Directed bench for mul_share_seq: expected products are pushed on accept and checked by a response monitor.
module tb_mul_share_seq;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_src1 = '0;
    logic [NUM_REQ-1:0][31:0] req_src2 = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic [ID_W-1:0]          rsp_id;
    logic [31:0]              rsp_lo, rsp_hi;
    logic                     busy;

    always #5 clk = ~clk;

    mul_share_seq #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi),
        .busy      (busy)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     hi;
        logic [31:0]     lo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.id = ID_W'(id);
        e.hi = hi;
        e.lo = lo;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_hi", 64'(rsp_hi), 64'(e.hi));
                check("rsp_lo", 64'(rsp_lo), 64'(e.lo));
            end
        end
    end

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        bit ok;
        @(posedge clk); #1;
        req_src1[id]  = a;
        req_src2[id]  = b;
        req_valid[id] = 1'b1;
        wait_grant(id, ok);
        if (ok) push_exp(id, ehi, elo);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    // Contention table: grant order and hand-computed products.
    int          c_id  [4] = '{0, 1, 0, 1};
    logic [31:0] c_a   [4] = '{32'h0001_0000, 32'h1234_5678, 32'h8000_0000, 32'h0000_FFFF};
    logic [31:0] c_b   [4] = '{32'h0001_0000, 32'h0000_0010, 32'h8000_0000, 32'h0000_FFFF};
    logic [31:0] c_hi  [4] = '{32'h0000_0001, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000};
    logic [31:0] c_lo  [4] = '{32'h0000_0000, 32'h2345_6780, 32'h0000_0000, 32'hFFFE_0001};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit ok;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_lo",    64'(rsp_lo),    64'd0);
        check("rst_rsp_hi",    64'(rsp_hi),    64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Single op with latency check: rsp_valid first high in cycle 6
        @(posedge clk); #1;
        req_src1[0] = 32'h0001_0002;
        req_src2[0] = 32'h0003_0004;
        req_valid[0] = 1'b1;
        wait_grant(0, ok);
        check("t1_ready", 64'(req_ready), 64'b01);
        if (ok) push_exp(0, 32'h0000_0003, 32'h000A_0008);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check("t1_busy", 64'(busy), 64'd1);
            if (k < 6) check("t1_rsp_early", 64'(rsp_valid), 64'd0);
            else       check("t1_rsp_cycle6", 64'(rsp_valid), 64'd1);
        end
        wait_idle();

        // Operand extremes
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_idle();
        run_op(1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
        wait_idle();

        // Contention from reset: grant order 0,1,0,1
        pulse_reset();
        @(posedge clk); #1;
        req_src1[0] = c_a[0]; req_src2[0] = c_b[0];
        req_src1[1] = c_a[1]; req_src2[1] = c_b[1];
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            ok = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (req_ready != '0) begin
                    ok = 1'b1;
                    break;
                end
                if (busy) check("cont_ready_busy", 64'(req_ready), 64'd0);
            end
            if (!ok) begin
                check("cont_timeout", 64'd0, 64'd1);
                break;
            end
            check("cont_grant", 64'(req_ready), 64'd1 << c_id[n]);
            push_exp(c_id[n], c_hi[n], c_lo[n]);
            @(posedge clk); #1;
            if (n + 2 < 4) begin
                req_src1[c_id[n]] = c_a[n+2];
                req_src2[c_id[n]] = c_b[n+2];
            end else begin
                req_valid[c_id[n]] = 1'b0;
            end
        end
        req_valid = '0;
        wait_idle();

        // Backpressure with a competing request pending
        @(posedge clk); #1 rsp_ready = 1'b0;
        run_op(0, 32'hFFFF_0000, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_0000);
        req_src1[1] = 32'h0000_0005;
        req_src2[1] = 32'h0000_0006;
        req_valid[1] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bp_rsp_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_hi",    64'(rsp_hi),    64'h0000_FFFF);
            check("bp_rsp_lo",    64'(rsp_lo),    64'hFFFF_0000);
            check("bp_rsp_id",    64'(rsp_id),    64'd0);
            check("bp_busy",      64'(busy),      64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready    = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
        check("bp_idle",     64'(busy),      64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset during ISSUE step 2, then a clean op
        @(posedge clk); #1;
        req_src1[0] = 32'hFFFF_FFFF;
        req_src2[0] = 32'hFFFF_FFFF;
        req_valid[0] = 1'b1;
        wait_grant(0, ok);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp_lo",    64'(rsp_lo),    64'd0);
        check("mid_rst_rsp_hi",    64'(rsp_hi),    64'd0);
        check("mid_rst_rsp_id",    64'(rsp_id),    64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        run_op(0, 32'd7, 32'd9, 32'd0, 32'd63);
        wait_idle();

        // Withdrawn request while busy leaves rr_ptr at 1
        run_op(0, 32'd3, 32'd5, 32'd0, 32'd15);
        req_src1[1] = 32'h0000_0010;
        req_src2[1] = 32'h0000_0010;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wd_ready_busy", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        req_src1[0] = 32'd2;
        req_src2[0] = 32'd3;
        req_valid = 2'b11;
        wait_grant(1, ok);
        check("wd_rr_grant", 64'(req_ready), 64'b10);
        if (ok) push_exp(1, 32'd0, 32'h0000_0100);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_grant(0, ok);
        if (ok) push_exp(0, 32'd0, 32'd6);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
